// File: rtl/typing_session_if.sv
// Bus bundle between the typing-session controller and its prompt ROM, UART rx/tx,
// stopwatch and status consumers. master = controller side, slave = environment side.
interface typing_session_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ERR_W  = 4
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              sw_clear;
  logic              sw_run;
  logic [ADDR_W-1:0] char_count;
  logic [ERR_W-1:0]  err_count;
  logic              done;
  logic              passed;

  modport master (
    input  start, rom_data, rx_valid, rx_data, tx_ready,
    output rom_addr, tx_valid, tx_data, sw_clear, sw_run, char_count, err_count, done, passed
  );

  modport slave (
    output start, rom_data, rx_valid, rx_data, tx_ready,
    input  rom_addr, tx_valid, tx_data, sw_clear, sw_run, char_count, err_count, done, passed
  );
endinterface

// File: rtl/typing_session_ctrl.sv
// Typing-test session controller: streams a null-terminated prompt from a synchronous ROM
// to the UART transmitter, then checks and echoes each received key, counting correct
// characters and errors and driving the stopwatch.
// Optional backspace support is enabled by defining TYPING_BACKSPACE_EN.
module typing_session_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PROMPT_BASE = 0,
  parameter int unsigned MAX_ERRORS  = 3,
  parameter int unsigned ERR_W       = 4
) (
  input logic               clk,
  input logic               reset,
  typing_session_if.master  bus
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(PROMPT_BASE);
  localparam logic [ERR_W-1:0]  MaxErr   = ERR_W'(MAX_ERRORS);
`ifdef TYPING_BACKSPACE_EN
  localparam logic [DATA_W-1:0] KeyBs    = DATA_W'(8'h08);
`endif

  typedef enum logic [3:0] {
    StIdle, StClear, StFetchP, StShow, StRewind, StFetchK,
    StArmed, StWaitKey, StEcho, StCompare, StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              sw_clear_q, sw_clear_d;
  logic              sw_run_q, sw_run_d;
  logic [ADDR_W-1:0] char_count_q, char_count_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              done_q, done_d;
  logic              passed_q, passed_d;
  logic [DATA_W-1:0] key_q, key_d;
  // First cycle in a fetch state only lets the synchronous ROM catch up with rom_addr.
  logic              rom_wait_q, rom_wait_d;
  // Last ROM address was matched; the address is pinned instead of wrapping.
  logic              exhausted_q, exhausted_d;
  // The echo in flight is a backspace, not a key to compare.
  logic              bs_q, bs_d;
  logic [ERR_W-1:0]  err_next;

  // Next-state and registered-output computation for the session FSM.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    sw_clear_d   = 1'b0;
    sw_run_d     = sw_run_q;
    char_count_d = char_count_q;
    err_count_d  = err_count_q;
    done_d       = done_q;
    passed_d     = passed_q;
    key_d        = key_q;
    rom_wait_d   = rom_wait_q;
    exhausted_d  = exhausted_q;
    bs_d         = bs_q;
    err_next     = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;

    unique case (state_q)
      StIdle, StFinish: begin
        if (bus.start) begin
          state_d      = StClear;
          sw_clear_d   = 1'b1;
          sw_run_d     = 1'b0;
          char_count_d = '0;
          err_count_d  = '0;
          rom_addr_d   = BaseAddr;
          done_d       = 1'b0;
          passed_d     = 1'b0;
          exhausted_d  = 1'b0;
          bs_d         = 1'b0;
        end
      end

      StClear: begin
        rom_addr_d = BaseAddr;
        rom_wait_d = 1'b1;
        state_d    = StFetchP;
      end

      StFetchP: begin
        if (rom_wait_q) begin
          rom_wait_d = 1'b0;
        end else if (bus.rom_data == '0) begin
          state_d = StRewind;
        end else begin
          tx_data_d  = bus.rom_data;
          tx_valid_d = 1'b1;
          state_d    = StShow;
        end
      end

      StShow: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          if (rom_addr_q == '1) begin
            state_d = StRewind;
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
            rom_wait_d = 1'b1;
            state_d    = StFetchP;
          end
        end
      end

      StRewind: begin
        rom_addr_d  = BaseAddr;
        exhausted_d = 1'b0;
        rom_wait_d  = 1'b1;
        state_d     = StFetchK;
      end

      StFetchK: begin
        if (rom_wait_q) begin
          rom_wait_d = 1'b0;
        end else if (exhausted_q || bus.rom_data == '0) begin
          done_d   = 1'b1;
          passed_d = 1'b1;
          sw_run_d = 1'b0;
          state_d  = StFinish;
        end else begin
          // sw_run is still low only before the first keystroke of the session.
          state_d = sw_run_q ? StWaitKey : StArmed;
        end
      end

      StArmed: begin
        if (bus.rx_valid) begin
          sw_run_d   = 1'b1;
          key_d      = bus.rx_data;
          tx_data_d  = bus.rx_data;
          tx_valid_d = 1'b1;
          state_d    = StEcho;
        end
      end

      StWaitKey: begin
        if (bus.rx_valid) begin
`ifdef TYPING_BACKSPACE_EN
          if (bus.rx_data == KeyBs) begin
            // Nothing to erase: drop the key without an echo.
            if (char_count_q != '0) begin
              bs_d       = 1'b1;
              tx_data_d  = bus.rx_data;
              tx_valid_d = 1'b1;
              state_d    = StEcho;
            end
          end else begin
            key_d      = bus.rx_data;
            tx_data_d  = bus.rx_data;
            tx_valid_d = 1'b1;
            state_d    = StEcho;
          end
`else
          key_d      = bus.rx_data;
          tx_data_d  = bus.rx_data;
          tx_valid_d = 1'b1;
          state_d    = StEcho;
`endif
        end
      end

      StEcho: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          if (bs_q) begin
            bs_d         = 1'b0;
            char_count_d = char_count_q - 1'b1;
            // A pinned address already points at the last character.
            if (exhausted_q) begin
              exhausted_d = 1'b0;
            end else begin
              rom_addr_d = rom_addr_q - 1'b1;
            end
            rom_wait_d = 1'b1;
            state_d    = StFetchK;
          end else begin
            state_d = StCompare;
          end
        end
      end

      StCompare: begin
        if (key_q == bus.rom_data) begin
          if (char_count_q != '1) begin
            char_count_d = char_count_q + 1'b1;
          end
          if (rom_addr_q == '1) begin
            exhausted_d = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
          end
          rom_wait_d = 1'b1;
          state_d    = StFetchK;
        end else begin
          err_count_d = err_next;
          if (err_next == MaxErr) begin
            done_d   = 1'b1;
            passed_d = 1'b0;
            sw_run_d = 1'b0;
            state_d  = StFinish;
          end else begin
            state_d = StWaitKey;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Session FSM state and all registered outputs; reset aborts any pending transmit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      rom_addr_q   <= BaseAddr;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      sw_clear_q   <= 1'b0;
      sw_run_q     <= 1'b0;
      char_count_q <= '0;
      err_count_q  <= '0;
      done_q       <= 1'b0;
      passed_q     <= 1'b0;
      key_q        <= '0;
      rom_wait_q   <= 1'b0;
      exhausted_q  <= 1'b0;
      bs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      sw_clear_q   <= sw_clear_d;
      sw_run_q     <= sw_run_d;
      char_count_q <= char_count_d;
      err_count_q  <= err_count_d;
      done_q       <= done_d;
      passed_q     <= passed_d;
      key_q        <= key_d;
      rom_wait_q   <= rom_wait_d;
      exhausted_q  <= exhausted_d;
      bs_q         <= bs_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.sw_clear   = sw_clear_q;
  assign bus.sw_run     = sw_run_q;
  assign bus.char_count = char_count_q;
  assign bus.err_count  = err_count_q;
  assign bus.done       = done_q;
  assign bus.passed     = passed_q;

endmodule

// File: tb/tb_typing_session_ctrl.sv
// Directed bench for typing_session_ctrl: prompt streaming, keystroke checking, error
// limit, transmit stall, mid-session reset, backspace handling and empty prompt.
module tb_typing_session_ctrl;

  localparam int unsigned AddrW = 8;
  localparam int unsigned DataW = 8;
  localparam int unsigned ErrW  = 4;

  logic clk;
  logic reset;

  typing_session_if #(.ADDR_W(AddrW), .DATA_W(DataW), .ERR_W(ErrW)) bus ();

  typing_session_ctrl #(
    .ADDR_W(AddrW), .DATA_W(DataW), .PROMPT_BASE(0), .MAX_ERRORS(3), .ERR_W(ErrW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] txq [$];
  logic [7:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int sw_clear_total = 0;
  int stall_violations = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  int clr0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous prompt ROM.
  always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

  // Transfer capture, stopwatch-clear counting and stall-stability monitor.
  always @(posedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
      if (bus.sw_clear) sw_clear_total <= sw_clear_total + 1;
      if (prev_stall && (!bus.tx_valid || bus.tx_data != prev_data))
        stall_violations <= stall_violations + 1;
      prev_stall <= bus.tx_valid && !bus.tx_ready;
      prev_data  <= bus.tx_data;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] k);
    bus.rx_valid = 1'b1;
    bus.rx_data  = k;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (bus.done) break;
      tick();
    end
    check_val("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic expect_tx(input string tag);
    check_val({tag, "_count"}, 32'(txq.size()), 32'(exp_q.size()));
    for (int i = 0; i < txq.size() && i < exp_q.size(); i++)
      check_val(tag, 32'(txq[i]), 32'(exp_q[i]));
    txq.delete();
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h41;
    mem[1] = 8'h42;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b1;
    wait_cycles(2);

    // Reset state.
    check_val("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check_val("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check_val("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check_val("rst_sw_run", 32'(bus.sw_run), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_counts", {16'(bus.char_count), 16'(bus.err_count)}, 32'd0);
    reset = 1'b0;
    tick();

    // Prompt "AB" then correct keys.
    clr0 = sw_clear_total;
    pulse_start();
    wait_cycles(20);
    exp_q = '{8'h41, 8'h42};
    expect_tx("prompt_ab");
    check_val("sw_clear_once", 32'(sw_clear_total - clr0), 32'd1);
    check_val("sw_run_idle", 32'(bus.sw_run), 32'd0);
    send_key(8'h41);
    check_val("sw_run_rise", 32'(bus.sw_run), 32'd1);
    wait_cycles(8);
    check_val("cc_after_a", 32'(bus.char_count), 32'd1);
    send_key(8'h42);
    wait_done();
    exp_q = '{8'h41, 8'h42};
    expect_tx("echo_ab");
    check_val("pass_passed", 32'(bus.passed), 32'd1);
    check_val("pass_cc", 32'(bus.char_count), 32'd2);
    check_val("pass_err", 32'(bus.err_count), 32'd0);
    check_val("pass_sw_run", 32'(bus.sw_run), 32'd0);

    // Three mismatches reach the error limit.
    pulse_start();
    wait_cycles(20);
    exp_q = '{8'h41, 8'h42};
    expect_tx("prompt_err");
    send_key(8'h78);
    wait_cycles(8);
    send_key(8'h79);
    wait_cycles(8);
    send_key(8'h7a);
    wait_done();
    exp_q = '{8'h78, 8'h79, 8'h7a};
    expect_tx("echo_xyz");
    check_val("fail_passed", 32'(bus.passed), 32'd0);
    check_val("fail_err", 32'(bus.err_count), 32'd3);
    check_val("fail_cc", 32'(bus.char_count), 32'd0);

    // Transmit stall during the prompt, with an rx strobe that must be dropped.
    bus.tx_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_valid) break;
      tick();
    end
    check_val("stall_valid", 32'(bus.tx_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        send_key(8'h51);
      end else begin
        tick();
      end
      check_val("stall_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, 8'h41});
    end
    bus.tx_ready = 1'b1;
    wait_cycles(20);
    exp_q = '{8'h41, 8'h42};
    expect_tx("prompt_stall");
    check_val("rx_drop_run", 32'(bus.sw_run), 32'd0);
    check_val("rx_drop_err", 32'(bus.err_count), 32'd0);

    // Reset while an echo is stalled.
    bus.tx_ready = 1'b0;
    send_key(8'h41);
    wait_cycles(2);
    check_val("echo_pending", {22'd0, bus.sw_run, bus.tx_valid, bus.tx_data},
              {22'd0, 1'b1, 1'b1, 8'h41});
    reset = 1'b1;
    #1;
    check_val("abort_tx", {23'd0, bus.tx_valid, bus.tx_data}, 32'd0);
    check_val("abort_state", {14'd0, bus.sw_run, bus.done, bus.rom_addr, bus.char_count},
              32'd0);
    tick();
    reset = 1'b0;
    bus.tx_ready = 1'b1;
    tick();
    pulse_start();
    wait_cycles(20);
    exp_q = '{8'h41, 8'h42};
    expect_tx("prompt_replay");
    send_key(8'h41);
    wait_cycles(8);
    send_key(8'h42);
    wait_done();
    txq.delete();

    // Backspace sequence A, BS, A, B.
    pulse_start();
    wait_cycles(20);
    txq.delete();
    send_key(8'h41);
    wait_cycles(8);
    check_val("bs_cc1", 32'(bus.char_count), 32'd1);
    send_key(8'h08);
    wait_cycles(8);
`ifdef TYPING_BACKSPACE_EN
    check_val("bs_cc2", 32'(bus.char_count), 32'd0);
`else
    check_val("bs_cc2", 32'(bus.char_count), 32'd1);
`endif
    send_key(8'h41);
    wait_cycles(8);
    check_val("bs_cc3", 32'(bus.char_count), 32'd1);
    send_key(8'h42);
    wait_done();
    check_val("bs_cc4", 32'(bus.char_count), 32'd2);
    check_val("bs_passed", 32'(bus.passed), 32'd1);
`ifdef TYPING_BACKSPACE_EN
    check_val("bs_err", 32'(bus.err_count), 32'd0);
`else
    // 0x08 and the retyped 'A' both mismatch the expected 'B'.
    check_val("bs_err", 32'(bus.err_count), 32'd2);
`endif
    exp_q = '{8'h41, 8'h08, 8'h41, 8'h42};
    expect_tx("bs_echo");

    // Empty prompt.
    mem[0] = 8'h00;
    pulse_start();
    wait_done();
    check_val("empty_tx", 32'(txq.size()), 32'd0);
    check_val("empty_passed", 32'(bus.passed), 32'd1);
    check_val("empty_sw_run", 32'(bus.sw_run), 32'd0);
    check_val("empty_cc", 32'(bus.char_count), 32'd0);

    check_val("tx_stable", 32'(stall_violations), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
